// File: rtl/pcm_uart_tx_streamer.sv
// Stereo PCM frame -> 8N1 UART streamer in playback byte order; optional 0xA5 sync prefix via PCM_TX_SYNC_EN.
// Start bit drives one cycle after the CTS_WAIT cycle; frame_ready only in IDLE, cts pauses at byte boundaries.
module pcm_uart_tx_streamer #(
   parameter int CLK_FREQ = 12_000_000,
   parameter int BAUDRATE = 3_000_000,
   parameter int BITS     = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [BITS-1:0] frame_data,
   input  logic            frame_valid,
   output logic            frame_ready,
   input  logic            cts,
   output logic            tx,
   output logic            busy,
   output logic [15:0]     frames_sent
);

   localparam int DIV    = CLK_FREQ / BAUDRATE;
   localparam int CW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int NBYTES = BITS / 8;
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

`ifdef PCM_TX_SYNC_EN
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [2:0] LAST_BYTE = 3'(NBYTES);
`else
   localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      CTS_WAIT,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   baud_cnt, baud_nxt;
   logic [2:0]      bit_cnt, bit_nxt;
   logic [2:0]      byte_idx, byte_nxt;
   logic [7:0]      shreg, shreg_nxt;
   logic [BITS-1:0] frame_q, frame_nxt;
   logic            busy_nxt;
   logic [15:0]     sent_nxt;
   logic            tx_nxt;
   logic            baud_tick;

   // Wire order matches the receiver: L lo, L hi, R lo, R hi (sync byte first when enabled).
   function automatic logic [7:0] wire_byte(input logic [2:0] idx, input logic [BITS-1:0] d);
      logic [7:0] b;
      logic [2:0] k;
`ifdef PCM_TX_SYNC_EN
      k = idx - 3'd1;
`else
      k = idx;
`endif
      case (k)
         3'd0:    b = d[23:16];
         3'd1:    b = d[31:24];
         3'd2:    b = d[7:0];
         default: b = d[15:8];
      endcase
`ifdef PCM_TX_SYNC_EN
      if (idx == 3'd0) b = SYNC_BYTE;
`endif
      return b;
   endfunction

   assign baud_tick = (baud_cnt == BAUD_LAST);

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_cnt;
      byte_nxt  = byte_idx;
      shreg_nxt = shreg;
      frame_nxt = frame_q;
      busy_nxt  = busy;
      sent_nxt  = frames_sent;
      tx_nxt    = 1'b1;

      case (state)
         IDLE: begin
            if (frame_ready && frame_valid) begin
               frame_nxt = frame_data;
               byte_nxt  = 3'd0;
               busy_nxt  = 1'b1;
               state_nxt = CTS_WAIT;
            end
         end
         CTS_WAIT: begin
            baud_nxt = '0;
            if (cts) begin
               shreg_nxt = wire_byte(byte_idx, frame_q);
               state_nxt = START;
            end
         end
         START: begin
            if (baud_tick) begin
               baud_nxt  = '0;
               bit_nxt   = 3'd0;
               state_nxt = DATA;
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_tick) begin
               baud_nxt  = '0;
               shreg_nxt = {1'b0, shreg[7:1]};
               if (bit_cnt == 3'd7) begin
                  state_nxt = STOP;
               end else begin
                  bit_nxt = bit_cnt + 3'd1;
               end
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_tick) begin
               baud_nxt = '0;
               if (byte_idx == LAST_BYTE) begin
                  busy_nxt  = 1'b0;
                  sent_nxt  = frames_sent + 16'd1;
                  state_nxt = IDLE;
               end else begin
                  // The byte-boundary cts check is folded into the stop bit's last
                  // cycle so that an unthrottled frame has no inter-byte gap.
                  byte_nxt = byte_idx + 3'd1;
                  if (cts) begin
                     shreg_nxt = wire_byte(byte_nxt, frame_q);
                     state_nxt = START;
                  end else begin
                     state_nxt = CTS_WAIT;
                  end
               end
            end else begin
               baud_nxt = baud_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase

      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
         default: tx_nxt = 1'b1;
      endcase
   end

   // tx is registered from the next-state decode so the line never glitches.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         bit_cnt     <= '0;
         byte_idx    <= '0;
         shreg       <= '0;
         frame_q     <= '0;
         busy        <= 1'b0;
         frames_sent <= '0;
         tx          <= 1'b1;
         frame_ready <= 1'b0;
      end else begin
         state       <= state_nxt;
         baud_cnt    <= baud_nxt;
         bit_cnt     <= bit_nxt;
         byte_idx    <= byte_nxt;
         shreg       <= shreg_nxt;
         frame_q     <= frame_nxt;
         busy        <= busy_nxt;
         frames_sent <= sent_nxt;
         tx          <= tx_nxt;
         frame_ready <= (state_nxt == IDLE);
      end
   end

endmodule
